// File: rtl/reg_bank_arb.sv
// Round-robin arbitrated write port in front of an NREG x DW register bank.
// Optional burst lock is enabled by defining REG_ARB_LOCK_EN.
module reg_bank_arb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned NREG = 8,
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   wr_addr,
    input  logic [NREQ*DW-1:0]   wr_data,
`ifdef REG_ARB_LOCK_EN
    input  logic [NREQ-1:0]      lock,
`endif
    output logic [NREQ-1:0]      gnt,
    output logic                 busy,
    input  logic [AW-1:0]        rd_addr,
    output logic [DW-1:0]        rd_data
);

    localparam int unsigned PW = $clog2(NREQ);

    typedef enum logic [0:0] {StIdle, StWrite} state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [PW-1:0]   win_q, win_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [DW-1:0]   bank_q [NREG];

    logic            relock;
    logic            found;
    logic [NREQ-1:0] cand;
    logic [PW-1:0]   start;
    logic [PW-1:0]   idx;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_data;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (32'(p) == NREQ - 1) ? '0 : p + 1'b1;
    endfunction

    assign w_addr = wr_addr[32'(win_q) * AW +: AW];
    assign w_data = wr_data[32'(win_q) * DW +: DW];

    always_comb begin
        relock  = 1'b0;
`ifdef REG_ARB_LOCK_EN
        relock  = (state_q == StWrite) && lock[win_q] && req[win_q];
`endif
        cand    = req;
        start   = ptr_q;
        // Decide the next winner during WRITE as if the write had already retired.
        if (state_q == StWrite) begin
            cand  = req & ~gnt_q;
            start = inc(win_q);
        end
        found = 1'b0;
        win_d = win_q;
        idx   = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx = PW'((32'(start) + 32'(k)) % NREQ);
            if (!found && cand[idx]) begin
                found = 1'b1;
                win_d = idx;
            end
        end
        if (relock) begin
            found = 1'b1;
            win_d = win_q;
        end
        state_d = found ? StWrite : StIdle;
        gnt_d   = found ? (NREQ'(1) << win_d) : '0;
        ptr_d   = ptr_q;
        if (state_q == StWrite && !relock) begin
            ptr_d = inc(win_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            win_q   <= '0;
            ptr_q   <= '0;
            for (int i = 0; i < int'(NREG); i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
            // Out-of-range writes are dropped; the grant still completes.
            if (state_q == StWrite && 32'(w_addr) < NREG) begin
                bank_q[w_addr] <= w_data;
            end
        end
    end

    assign gnt     = gnt_q;
    assign busy    = |gnt_q;
    assign rd_data = (32'(rd_addr) < NREG) ? bank_q[rd_addr] : '0;

endmodule

// File: tb/tb_reg_bank_arb.sv
// Self-checking bench for reg_bank_arb (NREQ=4, NREG=6, DW=32, AW=3).
// Grant expectations flow through a scoreboard queue; readbacks are table/constant driven.
module tb_reg_bank_arb;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [11:0]  wr_addr;
    logic [127:0] wr_data;
    logic [3:0]   lock;
    logic [3:0]   gnt;
    logic         busy;
    logic [2:0]   rd_addr;
    logic [31:0]  rd_data;

    int nvec = 0;
    int nerr = 0;
    logic [3:0] sb_q[$];

    reg_bank_arb #(
        .NREQ(4),
        .NREG(6),
        .DW  (32),
        .AW  (3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
`ifdef REG_ARB_LOCK_EN
        .lock   (lock),
`endif
        .gnt    (gnt),
        .busy   (busy),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned who;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [3:0]  exp_gnt;
        logic [31:0] exp_old;
        logic [31:0] exp_new;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_gnt(input string name);
        logic [3:0] e;
        if (sb_q.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL %s: scoreboard empty, got gnt %b", name, gnt);
        end else begin
            e = sb_q.pop_front();
            check(name, 32'(gnt), 32'(e));
        end
    endtask

    task automatic set_src(input int unsigned i, input logic [2:0] a, input logic [31:0] d);
        wr_addr[i*3 +: 3]  = a;
        wr_data[i*32 +: 32] = d;
    endtask

    task automatic read_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
        rd_addr = a;
        #1;
        check(name, rd_data, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        lock = '0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        logic [3:0] prev;
        vecs[0] = '{0, 3'd3, 32'hDEADBEEF, 4'b0001, 32'h0,        32'hDEADBEEF};
        vecs[1] = '{2, 3'd5, 32'h12345678, 4'b0100, 32'h0,        32'h12345678};
        vecs[2] = '{3, 3'd7, 32'hCAFEF00D, 4'b1000, 32'h0,        32'h0};
        vecs[3] = '{1, 3'd0, 32'hA5A5A5A5, 4'b0010, 32'h0,        32'hA5A5A5A5};
        vecs[4] = '{3, 3'd3, 32'h0BADC0DE, 4'b1000, 32'hDEADBEEF, 32'h0BADC0DE};
        vecs[5] = '{1, 3'd6, 32'hFFFFFFFF, 4'b0010, 32'h0,        32'h0};

        rst = 1'b1; req = '0; lock = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        step();
        check("reset_gnt", 32'(gnt), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        do_reset();
        check("idle_gnt", 32'(gnt), 32'h0);
        check("idle_busy", 32'(busy), 32'h0);
        for (int a = 0; a < 8; a++) read_chk($sformatf("reset_rd%0d", a), 3'(a), 32'h0);

        // Single-requester writes: grant latency, read-during-write, visible next cycle.
        for (int v = 0; v < 6; v++) begin
            set_src(vecs[v].who, vecs[v].addr, vecs[v].data);
            req = 4'(1) << vecs[v].who;
            sb_q.push_back(vecs[v].exp_gnt);
            sb_q.push_back(4'b0000);
            step();
            check_gnt($sformatf("vec%0d_gnt", v));
            check($sformatf("vec%0d_busy", v), 32'(busy), 32'h1);
            read_chk($sformatf("vec%0d_old", v), vecs[v].addr, vecs[v].exp_old);
            step();
            req = '0;
            check_gnt($sformatf("vec%0d_gnt_off", v));
            read_chk($sformatf("vec%0d_new", v), vecs[v].addr, vecs[v].exp_new);
            step();
        end
        read_chk("oor_keep3", 3'd3, 32'h0BADC0DE);
        read_chk("oor_keep5", 3'd5, 32'h12345678);
        read_chk("oor_keep0", 3'd0, 32'hA5A5A5A5);

        // Contention from rr_ptr=0: back-to-back round-robin grants.
        do_reset();
        for (int i = 0; i < 4; i++) set_src(i, 3'(i), 32'h1000_0000 + 32'(i) * 32'h11);
        req = 4'b1111;
        sb_q.push_back(4'b0001); sb_q.push_back(4'b0010);
        sb_q.push_back(4'b0100); sb_q.push_back(4'b1000);
        sb_q.push_back(4'b0000);
        prev = '0;
        for (int k = 0; k < 5; k++) begin
            step();
            req = req & ~prev;
            prev = sb_q.size() > 0 ? sb_q[0] : 4'b0000;
            check_gnt($sformatf("cont_gnt%0d", k));
        end
        req = '0;
        for (int i = 0; i < 4; i++)
            read_chk($sformatf("cont_rd%0d", i), 3'(i), 32'h1000_0000 + 32'(i) * 32'h11);
        read_chk("cont_rd4", 3'd4, 32'h0);

        // Fairness wrap: requester 3 went last, so 0 precedes 3.
        step();
        set_src(0, 3'd4, 32'h4444_0000);
        set_src(3, 3'd5, 32'h5555_0003);
        req = 4'b1001;
        sb_q.push_back(4'b0001); sb_q.push_back(4'b1000); sb_q.push_back(4'b0000);
        step(); check_gnt("wrap_first");
        step(); req = 4'b1000; check_gnt("wrap_second");
        step(); req = '0; check_gnt("wrap_idle");
        read_chk("wrap_rd4", 3'd4, 32'h4444_0000);
        read_chk("wrap_rd5", 3'd5, 32'h5555_0003);

        // Reset in the grant cycle discards the write.
        step();
        set_src(2, 3'd2, 32'h2222_2222);
        req = 4'b0100;
        sb_q.push_back(4'b0100); sb_q.push_back(4'b0000);
        step(); check_gnt("rstmid_gnt");
        rst = 1'b1;
        step(); rst = 1'b0; req = '0; check_gnt("rstmid_after");
        check("rstmid_busy", 32'(busy), 32'h0);
        read_chk("rstmid_rd2", 3'd2, 32'h0);

`ifdef REG_ARB_LOCK_EN
        // Move rr_ptr to 1, then a 3-cycle lock burst for requester 1.
        step();
        set_src(0, 3'd0, 32'h0);
        req = 4'b0001;
        sb_q.push_back(4'b0001);
        step(); check_gnt("lock_pre");
        step(); req = '0;
        step();
        for (int i = 0; i < 4; i++) set_src(i, 3'(i), 32'hB000_0000 + 32'(i));
        req = 4'b1111;
        lock = 4'b0010;
        sb_q.push_back(4'b0010); sb_q.push_back(4'b0010); sb_q.push_back(4'b0010);
        sb_q.push_back(4'b0100);
        step(); check_gnt("lock_b0");
        step(); check_gnt("lock_b1");
        step(); lock = '0; check_gnt("lock_b2");
        step(); req = '0; check_gnt("lock_next");
        step();
        read_chk("lock_rd1", 3'd1, 32'hB000_0001);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
